// File: rtl/mmc_cmd_layer_arbiter.sv
// Two-client round-robin arbiter and sequencer for the shared SPI MMC byte link (CMD17/CMD24 sub-layers).
// Latency: a request accepted in IDLE starts its sub-layer 1 cycle later; DONE follows the sub-layer END by 1 cycle.
// Backpressure: oREQx_READY is raised only in IDLE for the winner; clients hold VALID/RW/ADDR until READY is seen.
//
// Ports:
//   iCLOCK, iRESET_SYNC            clock, synchronous active-high reset
//   iREQx_VALID/RW/ADDR            client x request (RW: 1 = write, 0 = read)
//   oREQx_READY, oREQx_DONE        accept strobe and completion pulse for client x
//   oREQ_ERR                       marks a DONE pulse as a timeout abort
//   oGRANT_ID                      owning client, for the external data-buffer mux
//   oRD_START/oWR_START, oCMD_ADDR start pulses and latched address to the sub-layers
//   iRD_END/iWR_END                sub-layer completion pulses
//   iRD_MMC_*/iWR_MMC_*            sub-layer link outputs (REQ, CS, DATA)
//   oRD_MMC_*/oWR_MMC_*            gated link status (BUSY, VALID) to the sub-layers
//   oSUB_RESET                     synchronous reset to both sub-layers
//   oMMC_REQ/CS/DATA, iMMC_BUSY/VALID  shared link
//
// Optional feature macro: MMC_CMD_ARB_TIMEOUT_EN (RUN watchdog, aborts after TIMEOUT_CYCLES).

module mmc_cmd_layer_arbiter #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10000000
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iREQ0_VALID,
  input  logic        iREQ0_RW,
  input  logic [31:0] iREQ0_ADDR,
  output logic        oREQ0_READY,
  output logic        oREQ0_DONE,
  input  logic        iREQ1_VALID,
  input  logic        iREQ1_RW,
  input  logic [31:0] iREQ1_ADDR,
  output logic        oREQ1_READY,
  output logic        oREQ1_DONE,
  output logic        oREQ_ERR,
  output logic        oGRANT_ID,
  output logic        oRD_START,
  output logic        oWR_START,
  output logic [31:0] oCMD_ADDR,
  input  logic        iRD_END,
  input  logic        iWR_END,
  input  logic        iRD_MMC_REQ,
  input  logic        iRD_MMC_CS,
  input  logic [7:0]  iRD_MMC_DATA,
  input  logic        iWR_MMC_REQ,
  input  logic        iWR_MMC_CS,
  input  logic [7:0]  iWR_MMC_DATA,
  output logic        oRD_MMC_BUSY,
  output logic        oRD_MMC_VALID,
  output logic        oWR_MMC_BUSY,
  output logic        oWR_MMC_VALID,
  output logic        oSUB_RESET,
  output logic        oMMC_REQ,
  output logic        oMMC_CS,
  output logic [7:0]  oMMC_DATA,
  input  logic        iMMC_BUSY,
  input  logic        iMMC_VALID
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      b_state_q, b_state_d;
  logic        b_grant_q, b_grant_d;
  logic        b_last_q,  b_last_d;
  logic        b_rw_q,    b_rw_d;
  logic [31:0] b_addr_q,  b_addr_d;
  logic        sub_rst_q, sub_rst_d;

  logic any_vld;
  logic winner;
  logic sel_end;
  logic tmo_hit;

  // Reset masks every state-derived output so the reset cycle looks like IDLE
  // even when the registers still hold a mid-transaction state.
  logic in_idle, in_start, in_run, in_done;
  logic run_rd, run_wr;

  assign any_vld = iREQ0_VALID | iREQ1_VALID;
  // On a tie the client that did not win last time gets the grant.
  assign winner  = (iREQ0_VALID & iREQ1_VALID) ? ~b_last_q : iREQ1_VALID;
  assign sel_end = b_rw_q ? iWR_END : iRD_END;

  assign in_idle  = ~iRESET_SYNC & (b_state_q == ST_IDLE);
  assign in_start = ~iRESET_SYNC & (b_state_q == ST_START);
  assign in_run   = ~iRESET_SYNC & (b_state_q == ST_RUN);
  assign in_done  = ~iRESET_SYNC & (b_state_q == ST_DONE);
  assign run_rd   = in_run & ~b_rw_q;
  assign run_wr   = in_run &  b_rw_q;

`ifdef MMC_CMD_ARB_TIMEOUT_EN
  logic [23:0] tmo_cnt_q, tmo_cnt_d;
  logic        err_q, err_d;

  // An END in the same cycle as the limit wins, so no abort then.
  assign tmo_hit = in_run & ~sel_end & (tmo_cnt_q == TIMEOUT_CYCLES - 24'd1);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q;
    if (b_state_q == ST_START) begin
      tmo_cnt_d = 24'd0;
      err_d     = 1'b0;
    end else if (b_state_q == ST_RUN) begin
      tmo_cnt_d = tmo_cnt_q + 24'd1;
      if (tmo_hit) begin
        err_d = 1'b1;
      end
    end
    if (iRESET_SYNC) begin
      tmo_cnt_d = 24'd0;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge iCLOCK) begin
    tmo_cnt_q <= tmo_cnt_d;
    err_q     <= err_d;
  end

  assign oREQ_ERR = in_done & err_q;
`else
  assign tmo_hit  = 1'b0;
  assign oREQ_ERR = 1'b0;
`endif

  // Next-state logic; reset overrides everything at the end.
  always_comb begin
    b_state_d = b_state_q;
    b_grant_d = b_grant_q;
    b_last_d  = b_last_q;
    b_rw_d    = b_rw_q;
    b_addr_d  = b_addr_q;
    sub_rst_d = iRESET_SYNC | tmo_hit;

    case (b_state_q)
      ST_IDLE: begin
        if (any_vld) begin
          b_grant_d = winner;
          b_last_d  = winner;
          b_rw_d    = winner ? iREQ1_RW   : iREQ0_RW;
          b_addr_d  = winner ? iREQ1_ADDR : iREQ0_ADDR;
          b_state_d = ST_START;
        end
      end
      ST_START: b_state_d = ST_RUN;
      ST_RUN: begin
        if (sel_end || tmo_hit) begin
          b_state_d = ST_DONE;
        end
      end
      ST_DONE:  b_state_d = ST_IDLE;
      default:  b_state_d = ST_IDLE;
    endcase

    if (iRESET_SYNC) begin
      b_state_d = ST_IDLE;
      b_grant_d = 1'b0;
      b_last_d  = 1'b1;
      b_rw_d    = 1'b0;
      b_addr_d  = 32'd0;
    end
  end

  always_ff @(posedge iCLOCK) begin
    b_state_q <= b_state_d;
    b_grant_q <= b_grant_d;
    b_last_q  <= b_last_d;
    b_rw_q    <= b_rw_d;
    b_addr_q  <= b_addr_d;
    sub_rst_q <= sub_rst_d;
  end

  // Client handshake
  assign oREQ0_READY = in_idle & any_vld & ~winner;
  assign oREQ1_READY = in_idle & any_vld &  winner;
  assign oREQ0_DONE  = in_done & ~b_grant_q;
  assign oREQ1_DONE  = in_done &  b_grant_q;
  assign oGRANT_ID   = b_grant_q;

  // Sub-layer control
  assign oRD_START  = in_start & ~b_rw_q;
  assign oWR_START  = in_start &  b_rw_q;
  assign oCMD_ADDR  = b_addr_q;
  // Reset/timeout cycle plus one registered follow-on cycle.
  assign oSUB_RESET = iRESET_SYNC | tmo_hit | sub_rst_q;

  // Shared link mux: only the selected sub-layer drives it during RUN,
  // otherwise the link idles with CS deasserted.
  assign oMMC_REQ  = run_rd ? iRD_MMC_REQ  : (run_wr ? iWR_MMC_REQ  : 1'b0);
  assign oMMC_CS   = run_rd ? iRD_MMC_CS   : (run_wr ? iWR_MMC_CS   : 1'b1);
  assign oMMC_DATA = run_rd ? iRD_MMC_DATA : (run_wr ? iWR_MMC_DATA : 8'hFF);

  // A sub-layer that does not own the link always sees it busy with no data.
  assign oRD_MMC_BUSY  = run_rd ? iMMC_BUSY  : 1'b1;
  assign oRD_MMC_VALID = run_rd ? iMMC_VALID : 1'b0;
  assign oWR_MMC_BUSY  = run_wr ? iMMC_BUSY  : 1'b1;
  assign oWR_MMC_VALID = run_wr ? iMMC_VALID : 1'b0;

endmodule

// File: tb/tb_mmc_cmd_layer_arbiter.sv
// Self-checking bench for mmc_cmd_layer_arbiter: randomized client traffic and sub-layer link activity
// checked against a transaction-level model of the arbitration, sequencing and link-mux rules.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.

module tb_mmc_cmd_layer_arbiter;

  logic        iCLOCK = 1'b0;
  logic        iRESET_SYNC;
  logic        iREQ0_VALID, iREQ0_RW, oREQ0_READY, oREQ0_DONE;
  logic [31:0] iREQ0_ADDR;
  logic        iREQ1_VALID, iREQ1_RW, oREQ1_READY, oREQ1_DONE;
  logic [31:0] iREQ1_ADDR;
  logic        oREQ_ERR, oGRANT_ID, oRD_START, oWR_START;
  logic [31:0] oCMD_ADDR;
  logic        iRD_END, iWR_END;
  logic        iRD_MMC_REQ, iRD_MMC_CS, iWR_MMC_REQ, iWR_MMC_CS;
  logic [7:0]  iRD_MMC_DATA, iWR_MMC_DATA;
  logic        oRD_MMC_BUSY, oRD_MMC_VALID, oWR_MMC_BUSY, oWR_MMC_VALID;
  logic        oSUB_RESET, oMMC_REQ, oMMC_CS;
  logic [7:0]  oMMC_DATA;
  logic        iMMC_BUSY, iMMC_VALID;

  always #5 iCLOCK = ~iCLOCK;

  mmc_cmd_layer_arbiter #(.TIMEOUT_CYCLES(24'd100)) dut (
    .iCLOCK(iCLOCK), .iRESET_SYNC(iRESET_SYNC),
    .iREQ0_VALID(iREQ0_VALID), .iREQ0_RW(iREQ0_RW), .iREQ0_ADDR(iREQ0_ADDR),
    .oREQ0_READY(oREQ0_READY), .oREQ0_DONE(oREQ0_DONE),
    .iREQ1_VALID(iREQ1_VALID), .iREQ1_RW(iREQ1_RW), .iREQ1_ADDR(iREQ1_ADDR),
    .oREQ1_READY(oREQ1_READY), .oREQ1_DONE(oREQ1_DONE),
    .oREQ_ERR(oREQ_ERR), .oGRANT_ID(oGRANT_ID),
    .oRD_START(oRD_START), .oWR_START(oWR_START), .oCMD_ADDR(oCMD_ADDR),
    .iRD_END(iRD_END), .iWR_END(iWR_END),
    .iRD_MMC_REQ(iRD_MMC_REQ), .iRD_MMC_CS(iRD_MMC_CS), .iRD_MMC_DATA(iRD_MMC_DATA),
    .iWR_MMC_REQ(iWR_MMC_REQ), .iWR_MMC_CS(iWR_MMC_CS), .iWR_MMC_DATA(iWR_MMC_DATA),
    .oRD_MMC_BUSY(oRD_MMC_BUSY), .oRD_MMC_VALID(oRD_MMC_VALID),
    .oWR_MMC_BUSY(oWR_MMC_BUSY), .oWR_MMC_VALID(oWR_MMC_VALID),
    .oSUB_RESET(oSUB_RESET), .oMMC_REQ(oMMC_REQ), .oMMC_CS(oMMC_CS), .oMMC_DATA(oMMC_DATA),
    .iMMC_BUSY(iMMC_BUSY), .iMMC_VALID(iMMC_VALID)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Model state: what each client is presenting, who won last, and the
  // expected sub-layer reset level for the next IDLE check.
  logic        c_vld [2];
  logic        c_rw  [2];
  logic [31:0] c_addr[2];
  logic        exp_last;
  logic        exp_subrst;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic apply_clients();
    iREQ0_VALID = c_vld[0]; iREQ0_RW = c_rw[0]; iREQ0_ADDR = c_addr[0];
    iREQ1_VALID = c_vld[1]; iREQ1_RW = c_rw[1]; iREQ1_ADDR = c_addr[1];
  endtask

  task automatic new_req(input int i);
    c_vld[i]  = 1'b1;
    c_rw[i]   = 1'($urandom_range(0, 1));
    c_addr[i] = $urandom;
  endtask

  task automatic drive_sub_random();
    iRD_MMC_REQ  = 1'($urandom_range(0, 1));
    iRD_MMC_CS   = 1'($urandom_range(0, 1));
    iRD_MMC_DATA = 8'($urandom);
    iWR_MMC_REQ  = 1'($urandom_range(0, 1));
    iWR_MMC_CS   = 1'($urandom_range(0, 1));
    iWR_MMC_DATA = 8'($urandom);
    iMMC_BUSY    = 1'($urandom_range(0, 1));
    iMMC_VALID   = 1'($urandom_range(0, 1));
  endtask

  // Outside RUN the shared link idles and both sub-layers see BUSY=1/VALID=0.
  task automatic chk_link_idle(input string tag);
    chk(tag, {oMMC_REQ, oMMC_CS, oMMC_DATA, oRD_MMC_BUSY, oRD_MMC_VALID, oWR_MMC_BUSY, oWR_MMC_VALID},
        {1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0});
  endtask

  // One complete transaction starting from IDLE. With rnd set, clients are
  // randomized and may (re)raise requests while the link is owned.
  task automatic run_txn(input bit rnd, input int run_len);
    logic        w;
    logic        e_rw;
    logic [31:0] e_addr;
    if (rnd) begin
      for (int i = 0; i < 2; i++)
        if (!c_vld[i] && $urandom_range(0, 1) == 1) new_req(i);
      if (!c_vld[0] && !c_vld[1]) begin
        apply_clients();
        drive_sub_random();
        @(negedge iCLOCK);
        chk("ready_none", {oREQ1_READY, oREQ0_READY}, 2'b00);
        chk("subrst_none", oSUB_RESET, exp_subrst);
        exp_subrst = 1'b0;
        chk_link_idle("link_idle_none");
        next_cycle();
        new_req(int'($urandom_range(0, 1)));
      end
    end

    // IDLE / accept cycle
    apply_clients();
    drive_sub_random();
    @(negedge iCLOCK);
    w = (c_vld[0] && c_vld[1]) ? ~exp_last : c_vld[1];
    chk("ready_win", {oREQ1_READY, oREQ0_READY}, w ? 2'b10 : 2'b01);
    chk("subrst_idle", oSUB_RESET, exp_subrst);
    exp_subrst = 1'b0;
    chk("done_idle", {oREQ1_DONE, oREQ0_DONE, oRD_START, oWR_START}, 4'b0000);
    chk_link_idle("link_idle_accept");
    e_rw     = c_rw[w];
    e_addr   = c_addr[w];
    exp_last = w;
    next_cycle();

    // START: the winner may re-request with fresh RW/ADDR; the latched values must not change.
    c_vld[w] = 1'b0;
    if (rnd && $urandom_range(0, 2) == 0) new_req(int'(w));
    apply_clients();
    drive_sub_random();
    @(negedge iCLOCK);
    chk("start", {oWR_START, oRD_START}, e_rw ? 2'b10 : 2'b01);
    chk("cmd_addr", oCMD_ADDR, e_addr);
    chk("grant_start", oGRANT_ID, w);
    chk("ready_start", {oREQ1_READY, oREQ0_READY}, 2'b00);
    chk("subrst_start", oSUB_RESET, 1'b0);
    chk_link_idle("link_idle_start");
    next_cycle();

    // RUN
    for (int k = 0; k < run_len; k++) begin
      drive_sub_random();
      if (e_rw) begin
        iWR_END = (k == run_len - 1);
        iRD_END = ($urandom_range(0, 3) == 0);
      end else begin
        iRD_END = (k == run_len - 1);
        iWR_END = ($urandom_range(0, 3) == 0);
      end
      if (rnd)
        for (int i = 0; i < 2; i++)
          if (!c_vld[i] && $urandom_range(0, 3) == 0) new_req(i);
      apply_clients();
      @(negedge iCLOCK);
      if (e_rw) begin
        chk("mux_wr", {oMMC_REQ, oMMC_CS, oMMC_DATA}, {iWR_MMC_REQ, iWR_MMC_CS, iWR_MMC_DATA});
        chk("status_wr", {oWR_MMC_BUSY, oWR_MMC_VALID, oRD_MMC_BUSY, oRD_MMC_VALID},
            {iMMC_BUSY, iMMC_VALID, 2'b10});
      end else begin
        chk("mux_rd", {oMMC_REQ, oMMC_CS, oMMC_DATA}, {iRD_MMC_REQ, iRD_MMC_CS, iRD_MMC_DATA});
        chk("status_rd", {oRD_MMC_BUSY, oRD_MMC_VALID, oWR_MMC_BUSY, oWR_MMC_VALID},
            {iMMC_BUSY, iMMC_VALID, 2'b10});
      end
      chk("ready_run", {oREQ1_READY, oREQ0_READY}, 2'b00);
      chk("done_run", {oREQ1_DONE, oREQ0_DONE}, 2'b00);
      chk("grant_run", oGRANT_ID, w);
      next_cycle();
    end

    // DONE
    iRD_END = 1'b0;
    iWR_END = 1'b0;
    drive_sub_random();
    @(negedge iCLOCK);
    chk("done", {oREQ1_DONE, oREQ0_DONE}, w ? 2'b10 : 2'b01);
    chk("err", oREQ_ERR, 1'b0);
    chk("ready_done", {oREQ1_READY, oREQ0_READY}, 2'b00);
    chk("start_done", {oRD_START, oWR_START}, 2'b00);
    chk("grant_done", oGRANT_ID, w);
    chk_link_idle("link_idle_done");
    next_cycle();
  endtask

`ifdef MMC_CMD_ARB_TIMEOUT_EN
  // Read from client 0 with no END (abort expected) or END on the last allowed RUN cycle.
  task automatic tmo_txn(input bit with_end);
    int done_at;
    c_vld[0] = 1'b1; c_rw[0] = 1'b0; c_addr[0] = 32'h0000_1000;
    c_vld[1] = 1'b0;
    apply_clients();
    @(negedge iCLOCK);
    chk("tmo_ready", {oREQ1_READY, oREQ0_READY}, 2'b01);
    exp_last = 1'b0;
    next_cycle();
    c_vld[0] = 1'b0;
    apply_clients();
    next_cycle();
    done_at = -1;
    for (int k = 0; k < 300 && done_at < 0; k++) begin
      iRD_END = with_end && (k == 99);
      @(negedge iCLOCK);
      if (oREQ0_DONE) begin
        done_at = k;
        chk("tmo_err", oREQ_ERR, !with_end);
        chk("tmo_subrst_done", oSUB_RESET, !with_end);
      end else if (k == 99) begin
        chk("tmo_subrst_run", oSUB_RESET, !with_end);
      end
      next_cycle();
    end
    iRD_END = 1'b0;
    chk("tmo_done_cycle", done_at, 100);
  endtask
`endif

  initial begin
    iRESET_SYNC = 1'b1;
    iRD_END = 1'b0;
    iWR_END = 1'b0;
    exp_last   = 1'b1;
    exp_subrst = 1'b0;
    // Both clients present through reset: READY must stay masked.
    c_vld[0] = 1'b1; c_rw[0] = 1'b1; c_addr[0] = 32'h0000_0400;
    c_vld[1] = 1'b1; c_rw[1] = 1'b0; c_addr[1] = 32'h0000_0800;
    apply_clients();
    drive_sub_random();
    for (int r = 0; r < 2; r++) begin
      @(negedge iCLOCK);
      chk("rst_subrst", oSUB_RESET, 1'b1);
      chk("rst_ready", {oREQ1_READY, oREQ0_READY}, 2'b00);
      chk("rst_outs", {oREQ1_DONE, oREQ0_DONE, oREQ_ERR, oRD_START, oWR_START, oGRANT_ID}, 6'd0);
      chk("rst_addr", oCMD_ADDR, 32'd0);
      chk_link_idle("rst_link");
      next_cycle();
      drive_sub_random();
    end
    iRESET_SYNC = 1'b0;
    exp_subrst  = 1'b1;

    // Tie after reset: client 0 write first, then client 1 read.
    run_txn(1'b0, 40);
    run_txn(1'b0, 5);

    // Client 0 read of sector address 0x200, END 40 cycles after START.
    c_vld[0] = 1'b1; c_rw[0] = 1'b0; c_addr[0] = 32'h0000_0200;
    run_txn(1'b0, 40);

    for (int t = 0; t < 60; t++)
      run_txn(1'b1, int'($urandom_range(1, 12)));

    // Reset in the middle of a RUN owned by client 0.
    c_vld[0] = 1'b1; c_rw[0] = 1'b0; c_addr[0] = 32'h0000_0A00;
    c_vld[1] = 1'b0;
    apply_clients();
    @(negedge iCLOCK);
    chk("mid_ready", {oREQ1_READY, oREQ0_READY}, 2'b01);
    next_cycle();
    c_vld[0] = 1'b1;
    c_vld[1] = 1'b1; c_rw[1] = 1'b1; c_addr[1] = 32'h0000_0C00;
    apply_clients();
    next_cycle();
    drive_sub_random();
    next_cycle();
    iRESET_SYNC = 1'b1;
    drive_sub_random();
    @(negedge iCLOCK);
    chk("mid_rst_subrst", oSUB_RESET, 1'b1);
    chk("mid_rst_outs", {oREQ1_DONE, oREQ0_DONE, oREQ1_READY, oREQ0_READY, oRD_START, oWR_START}, 6'd0);
    chk_link_idle("mid_rst_link");
    next_cycle();
    iRESET_SYNC = 1'b0;
    // Client 0 won last, but reset restores the initial tie-break.
    exp_last   = 1'b1;
    exp_subrst = 1'b1;
    run_txn(1'b0, 3);
    run_txn(1'b0, 3);

`ifdef MMC_CMD_ARB_TIMEOUT_EN
    tmo_txn(1'b0);
    tmo_txn(1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/mmc_cmd_layer_arbiter.md
Name: mmc_cmd_layer_arbiter

Overview:
Two-requester arbiter and sequencer for the shared byte-level SPI MMC link.
- Accepts sector read/write requests from two clients and grants them round-robin.
- Starts the CMD17 (read) or CMD24 (write) command sub-layer with the latched sector address.
- Muxes the granted sub-layer's REQ/CS/DATA onto the shared link and gates BUSY/VALID back to it.
- Reports completion to the owning client.

Parameters:
- TIMEOUT_CYCLES, 24'd10000000, max cycles in RUN before abort (used only with the optional feature).

Ports:
- iCLOCK  in  1  clock
- iRESET_SYNC  in  1  reset, synchronous, active-high
- iREQ0_VALID  in  1  client 0 request valid
- iREQ0_RW  in  1  client 0 direction: 1 = write, 0 = read
- iREQ0_ADDR  in  32  client 0 sector/byte address
- oREQ0_READY  out  1  client 0 request accepted this cycle
- oREQ0_DONE  out  1  client 0 completion pulse
- iREQ1_VALID, iREQ1_RW, iREQ1_ADDR, oREQ1_READY, oREQ1_DONE: same as client 0, for client 1
- oREQ_ERR  out  1  qualifies a DONE pulse as aborted by timeout
- oGRANT_ID  out  1  owning client index, for the external data-buffer mux
- oRD_START  out  1  CMD17 sub-layer start pulse
- oWR_START  out  1  CMD24 sub-layer start pulse
- oCMD_ADDR  out  32  latched address to both sub-layers
- iRD_END  in  1  CMD17 sub-layer end pulse
- iWR_END  in  1  CMD24 sub-layer end pulse
- iRD_MMC_REQ, iRD_MMC_CS, iRD_MMC_DATA[7:0]  in  CMD17 sub-layer link outputs
- iWR_MMC_REQ, iWR_MMC_CS, iWR_MMC_DATA[7:0]  in  CMD24 sub-layer link outputs
- oRD_MMC_BUSY, oRD_MMC_VALID  out  1  gated link status to CMD17 sub-layer
- oWR_MMC_BUSY, oWR_MMC_VALID  out  1  gated link status to CMD24 sub-layer
- oSUB_RESET  out  1  synchronous reset pulse to both sub-layers
- oMMC_REQ  out  1  shared link request
- oMMC_CS  out  1  shared link chip select, active-low
- oMMC_DATA  out  8  shared link transmit byte
- iMMC_BUSY  in  1  shared link busy
- iMMC_VALID  in  1  shared link receive byte valid

Behaviour:
State machine:
- States: IDLE, START, RUN, DONE. Held in registers b_state, b_grant, b_last, b_rw, b_addr.
- IDLE:
  - If any valid: pick winner (both valid -> client != b_last; single -> that client).
  - Assert winner's oREQx_READY combinationally, this cycle only.
  - Latch b_grant, b_rw, b_addr; b_last <= winner; go START.
  - READY is never asserted outside IDLE.
- START (1 cycle): oRD_START=1 if b_rw=0, else oWR_START=1. Go RUN.
- RUN: wait for the END of the selected sub-layer. END from the non-selected sub-layer is ignored. On END go DONE.
- DONE (1 cycle): oREQ{b_grant}_DONE=1. Go IDLE.
- A new request can be accepted in the cycle after DONE. Accept-to-start latency is 1 cycle.

Link mux:
- RUN: oMMC_REQ/CS/DATA follow the selected sub-layer's inputs.
- Non-selected sub-layer sees BUSY=1, VALID=0.
- Selected sub-layer sees iMMC_BUSY / iMMC_VALID directly.
- IDLE, START, DONE: oMMC_REQ=0, oMMC_CS=1, oMMC_DATA=8'hFF; both sub-layers see BUSY=1, VALID=0.

Other outputs:
- oCMD_ADDR = b_addr.
- oGRANT_ID = b_grant, valid in START/RUN/DONE.

Reset (iRESET_SYNC=1 at clock edge):
- State -> IDLE; b_grant=0; b_last=1, so client 0 wins the first tie; b_rw=0; b_addr=0.
- oSUB_RESET=1 for the reset cycle plus 1 following cycle.
- All other outputs at their IDLE values: READY follows the combinational rule but is masked during reset; DONE=0; ERR=0; START=0.
- Reset mid-RUN aborts silently: no DONE is produced.

Boundaries:
- Client held valid through its own DONE is re-arbitrated fairly: the other client wins if it is also valid.
- RW/ADDR are sampled only in the accept cycle.

Optional Feature:
Macro MMC_CMD_ARB_TIMEOUT_EN.
- Enabled:
  - 24-bit counter cleared in START, incremented in RUN.
  - When it reaches TIMEOUT_CYCLES-1 with no END: oSUB_RESET pulses 2 cycles, state goes to DONE with oREQ_ERR=1 alongside the DONE pulse.
  - END arriving in the same cycle as the timeout wins: no error.
- Disabled:
  - No counter; RUN waits indefinitely.
  - oREQ_ERR tied 0.
  - oSUB_RESET is driven only by iRESET_SYNC.

Test Plan:
1. Client 0 read, addr 32'h0000_0200; iRD_END 40 cycles after START. Expect READY0 in cycle 0, oRD_START in cycle 1, oMMC_DATA mirrors iRD_MMC_DATA during RUN, DONE0 one cycle after END, oREQ_ERR=0.
2. Both clients valid after reset (client 0 write, client 1 read). Expect client 0 granted, oWR_START. After DONE0, client 1 granted with oRD_START and oGRANT_ID=1.
3. Client 1 request while client 0 in RUN. Expect READY1=0 until IDLE. oWR_MMC_BUSY=1 and oWR_MMC_VALID=0 throughout a read RUN. Spurious iWR_END is ignored.
4. Idle link check: oMMC_CS=1, oMMC_REQ=0, oMMC_DATA=8'hFF in IDLE/START/DONE, even with sub-layer inputs toggling.
5. iRESET_SYNC mid-RUN. Expect IDLE next cycle, no DONE, oSUB_RESET high for 2 cycles, next tie granted to client 0.
6. (TIMEOUT_EN, TIMEOUT_CYCLES=100) no END. Expect oSUB_RESET pulse, DONE with oREQ_ERR=1 at cycle 100 of RUN. Separately, END at cycle 99 gives ERR=0.
